// File: rtl/rr_arb_mux_grant.sv
// Combinational arbiter: picks one requesting channel by fixed priority or by
// a round-robin search starting at ptr. Produces a one-hot grant and its index.
module rr_arb_mux_grant #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] reqValid,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              mode,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grantIdx,
    output logic              grantVld
);

    localparam logic MODE_RR = 1'b1;

    always_comb begin
        int idx;
        logic [SEL_W-1:0] idxS;
        grant    = '0;
        grantIdx = '0;
        grantVld = 1'b0;
        idx      = 0;
        idxS     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            // Round-robin walks ptr, ptr+1, ... wrapping at NUM_CH, not at 2**SEL_W
            idx = (mode == MODE_RR) ? int'(ptr) + k : k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idxS = SEL_W'(idx);
            if (!grantVld && reqValid[idxS]) begin
                grant[idxS] = 1'b1;
                grantIdx    = idxS;
                grantVld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-to-1 arbitrated mux with a one-entry valid/ready output stage.
// Holds the round-robin pointer and the output register; arbitration is in rr_arb_mux_grant.
module rr_arb_mux #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  ptr;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grantIdx;
    logic              grantVld;
    logic              loadEn;
    logic              accept;
    logic [DATA_W-1:0] selData;
    logic              vldP1;
    logic [DATA_W-1:0] dataP1;
    logic [SEL_W-1:0]  selP1;

    rr_arb_mux_grant #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) uGrant (
        .reqValid (in_valid),
        .ptr      (ptr),
        .mode     (mode),
        .grant    (grant),
        .grantIdx (grantIdx),
        .grantVld (grantVld)
    );

    // Loading is allowed when empty or when the held word drains this cycle
    assign loadEn   = !vldP1 | out_ready;
    assign in_ready = grant & {NUM_CH{loadEn & !rst}};
    assign accept   = grantVld & loadEn & !rst;

    always_comb begin
        selData = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                selData = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---- stage p1: output register and round-robin pointer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vldP1  <= 1'b0;
            dataP1 <= '0;
            selP1  <= '0;
            ptr    <= '0;
        end else if (accept) begin
            vldP1  <= 1'b1;
            dataP1 <= selData;
            selP1  <= grantIdx;
            ptr    <= (grantIdx == SEL_W'(NUM_CH - 1)) ? '0 : grantIdx + 1'b1;
        end else if (out_ready) begin
            vldP1  <= 1'b0;
        end
    end

    assign out_valid = vldP1;
    assign out_data  = dataP1;
    assign out_sel   = selP1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: 4-channel instance checked against a reference
// model with an output scoreboard, plus a 3-channel instance for wrap behaviour.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, outReady;
    logic [3:0]  inValid;
    logic [15:0] inData;
    logic [3:0]  inReady;
    logic        outValid;
    logic [3:0]  outData;
    logic [1:0]  outSel;

    logic        rst3, mode3, outReady3;
    logic [2:0]  inValid3;
    logic [11:0] inData3;
    logic [2:0]  inReady3;
    logic        outValid3;
    logic [3:0]  outData3;
    logic [1:0]  outSel3;

    rr_arb_mux #(.NUM_CH(4), .DATA_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(inValid), .in_data(inData),
        .in_ready(inReady), .out_valid(outValid), .out_data(outData),
        .out_sel(outSel), .out_ready(outReady)
    );

    rr_arb_mux #(.NUM_CH(3), .DATA_W(4)) dut3 (
        .clk(clk), .rst(rst3), .mode(mode3), .in_valid(inValid3), .in_data(inData3),
        .in_ready(inReady3), .out_valid(outValid3), .out_data(outData3),
        .out_sel(outSel3), .out_ready(outReady3)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         sel;
        logic [3:0] data;
    } exp_t;
    exp_t sb[$];

    int         mPtr      = 0;
    bit         mOutValid = 1'b0;
    logic [3:0] mOutData  = 4'h0;
    logic [1:0] mOutSel   = 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelGrant(input logic [3:0] v, input int p, input logic m);
        if (!m) begin
            for (int i = 0; i < 4; i++) if (v[i]) return i;
            return -1;
        end
        for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // One clock of the 4-channel DUT: check in_ready before the edge, outputs after it
    task automatic step(input string tag);
        int         g;
        bit         ld, acc;
        logic [3:0] expRdy;
        exp_t       e;
        #1;
        g      = modelGrant(inValid, mPtr, mode);
        ld     = !mOutValid || outReady;
        acc    = (g >= 0) && ld && !rst;
        expRdy = acc ? 4'(1 << g) : 4'b0000;
        chk({tag, ".in_ready"}, 32'(inReady), 32'(expRdy));
        if (acc) begin
            e.sel  = g;
            e.data = inData[g*4 +: 4];
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mOutValid = 1'b0;
            mOutData  = 4'h0;
            mOutSel   = 2'd0;
            mPtr      = 0;
            sb.delete();
            chk({tag, ".rst_data"}, 32'(outData), 32'(0));
            chk({tag, ".rst_sel"}, 32'(outSel), 32'(0));
        end else if (acc) begin
            mPtr      = (g == 3) ? 0 : g + 1;
            mOutValid = 1'b1;
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                chk({tag, ".out_sel"}, 32'(outSel), 32'(e.sel));
                chk({tag, ".out_data"}, 32'(outData), 32'(e.data));
                mOutData = e.data;
                mOutSel  = 2'(e.sel);
            end
        end else if (outReady) begin
            mOutValid = 1'b0;
        end else if (mOutValid) begin
            chk({tag, ".held_data"}, 32'(outData), 32'(mOutData));
            chk({tag, ".held_sel"}, 32'(outSel), 32'(mOutSel));
        end
        chk({tag, ".out_valid"}, 32'(outValid), 32'(mOutValid));
    endtask

    task automatic step3(input string tag, input logic [2:0] expRdy, input bit chkOut,
                         input logic [1:0] expSel);
        #1;
        chk({tag, ".in_ready"}, 32'(inReady3), 32'(expRdy));
        @(posedge clk);
        #1;
        if (chkOut) begin
            chk({tag, ".out_valid"}, 32'(outValid3), 32'(1));
            chk({tag, ".out_sel"}, 32'(outSel3), 32'(expSel));
            chk({tag, ".out_data"}, 32'(outData3), 32'(inData3[expSel*4 +: 4]));
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; outReady = 1'b1; inValid = 4'b0000;
        inData = {4'h4, 4'h3, 4'h2, 4'h1};
        rst3 = 1'b1; mode3 = 1'b1; outReady3 = 1'b1; inValid3 = 3'b000;
        inData3 = {4'hC, 4'hB, 4'h9};

        step("reset");
        step("reset");

        // Fixed priority picks lowest requesting index
        rst = 1'b0; mode = 1'b0; inValid = 4'b1010;
        step("fix1010");
        chk("fix1010.sel", 32'(outSel), 32'(1));
        inValid = 4'b0000;
        step("drain");

        // Round-robin from a fresh pointer
        rst = 1'b1;
        step("rst2");
        rst = 1'b0; mode = 1'b1; inValid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step("rr");
            chk("rr.seq", 32'(outSel), 32'(i % 4));
        end

        // Backpressure: hold 4'hA while new requests wait
        inValid = 4'b0000;
        step("bp.drain");
        mode = 1'b0; inData = {4'h4, 4'h3, 4'h7, 4'hA}; inValid = 4'b0001; outReady = 1'b0;
        step("bp.load");
        chk("bp.load_a", 32'(outData), 32'hA);
        inValid = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step("bp.stall");
            chk("bp.stall_a", 32'(outData), 32'hA);
        end
        outReady = 1'b1;
        step("bp.release");
        chk("bp.release_data", 32'(outData), 32'h7);
        inValid = 4'b0000;
        step("bp.idle");

        // Mode switch continues round-robin after the last fixed grant
        mode = 1'b0; inValid = 4'b1111;
        step("ms.fix0");
        chk("ms.fix0_sel", 32'(outSel), 32'(0));
        step("ms.fix1");
        chk("ms.fix1_sel", 32'(outSel), 32'(0));
        mode = 1'b1;
        step("ms.rr");
        chk("ms.rr_sel", 32'(outSel), 32'(1));

        // Reset while a word is held under backpressure
        outReady = 1'b0;
        step("mr.hold");
        rst = 1'b1;
        step("mr.rst");
        chk("mr.valid", 32'(outValid), 32'(0));
        rst = 1'b0; outReady = 1'b1; mode = 1'b1; inValid = 4'b1111;
        step("mr.after");
        chk("mr.after_sel", 32'(outSel), 32'(0));

        // Three channels: round-robin wrap at NUM_CH-1
        step3("c3.rst", 3'b000, 1'b0, 2'd0);
        chk("c3.rst_valid", 32'(outValid3), 32'(0));
        rst3 = 1'b0; inValid3 = 3'b010;
        step3("c3.ch1", 3'b010, 1'b1, 2'd1);
        inValid3 = 3'b011;
        step3("c3.wrap", 3'b001, 1'b1, 2'd0);
        inValid3 = 3'b111;
        step3("c3.ptr1", 3'b010, 1'b1, 2'd1);
        inValid3 = 3'b100;
        step3("c3.ch2", 3'b100, 1'b1, 2'd2);
        inValid3 = 3'b111;
        step3("c3.wrap0", 3'b001, 1'b1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
